// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, widths.
package mdu_pkg;
  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV  = 1'b1;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DZERO  = 2'd3
  } mdu_state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit bus: request side and HI/LO result side.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV with HI/LO registers. Works on magnitudes, one
// product/quotient bit per cycle over a shared accumulator, then fixes signs.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int AW    = 2*WIDTH + 1;

  mdu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              op_q, neg_q, rneg_q;
  logic [WIDTH:0]    bmag;      // WIDTH+1 bits so |most-negative| is representable
  logic [AW-1:0]     acc, acc_step;
  logic              done_q, dz_q;
  logic [WIDTH-1:0]  hi_q, lo_q;

  logic              accept, last;
  logic [WIDTH-1:0]  amag_in;   // unsigned view: 2^(WIDTH-1) still fits
  logic [WIDTH:0]    bmag_in;
  logic [WIDTH:0]    msum, dsh, ddiff;
  logic              dge;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]  quo_s, rem_s;

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // A start arriving while done is still showing is left for the next cycle.
  assign accept = (state == IDLE) && bus.start && !done_q;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  // Operand magnitudes and per-iteration step/sign-fix arithmetic.
  always_comb begin
    amag_in = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    bmag_in = bus.b[WIDTH-1] ? (~{1'b1, bus.b} + 1'b1) : {1'b0, bus.b};
    // shift-add: upper half accumulates, multiplier bits shift out of the bottom
    msum    = acc[AW-1:WIDTH] + (acc[0] ? bmag : '0);
    // restoring divide: remainder in the upper half, dividend/quotient below
    dsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    dge     = (dsh >= bmag);
    ddiff   = dsh - bmag;
    if (op_q == MDU_DIV) acc_step = {(dge ? ddiff : dsh), acc[WIDTH-2:0], dge};
    else                 acc_step = {1'b0, msum, acc[WIDTH-1:1]};
    prod_s  = neg_q  ? (~acc[2*WIDTH-1:0] + 1'b1)     : acc[2*WIDTH-1:0];
    quo_s   = neg_q  ? (~acc[WIDTH-1:0] + 1'b1)       : acc[WIDTH-1:0];
    rem_s   = rneg_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ((bus.op == MDU_DIV) && (bus.b == '0)) ? DZERO : RUN;
      RUN:     if (last)   state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      DZERO:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, write HI/LO and pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= MDU_MULT;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      bmag   <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= (state == FINISH) || (state == DZERO);
      dz_q   <= (state == DZERO);
      case (state)
        IDLE: if (accept) begin
          op_q   <= bus.op;
          neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rneg_q <= bus.a[WIDTH-1];
          bmag   <= bmag_in;
          acc    <= {(WIDTH+1)'(0), amag_in};
          cnt    <= '0;
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          if (op_q == MDU_DIV) begin
            hi_q <= rem_s;
            lo_q <= quo_s;
          end else begin
            hi_q <= prod_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_s[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO come from a 64-bit
// behavioural model and are queued at issue time, popped at done.
module tb_mult_div_unit;
  import mdu_pkg::*;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo);
    exp_t e;
    longint sa, sbv, p, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == MDU_DIV && b == '0) begin
      e.hi = cur_hi; e.lo = cur_lo; e.dz = 1'b1;
    end else if (op == MDU_MULT) begin
      p = sa * sbv;
      e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.hi = r[31:0]; e.lo = q[31:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic push_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b, m_hi, m_lo);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Drive one request; operands are scrambled right after the start edge.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    push_exp(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = ~op; bus.a = $urandom; bus.b = $urandom;
  endtask

  // Bounded wait for done; n = negedge index after the start edge, -1 on timeout.
  task automatic wait_done(output int n, output int busy_cnt, output int dz_stray);
    n = -1; busy_cnt = 0; dz_stray = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin n = k; return; end
      if (bus.div_zero) dz_stray++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.op = MDU_MULT; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_done: got done=%b dz=%b expected 0/0", bus.done, bus.div_zero); end
    checks++; if (bus.hi !== '0 || bus.lo !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b done=%b expected 0/0", bus.busy, bus.done); end
  endtask

  task automatic test_mult();
    logic [W-1:0] ta [4] = '{32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    logic [W-1:0] tb [4] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    int n, bc, dzs;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(MDU_MULT, ta[i], tb[i]);
      wait_done(n, bc, dzs);
      e = sb.pop_front();
      checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency[%0d]: got %0d expected 33", i, n); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles[%0d]: got %0d expected 33", i, bc); end
      checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin errors++; $display("FAIL mult_result[%0d]: got %h_%h expected %h_%h", i, bus.hi, bus.lo, e.hi, e.lo); end
      checks++; if (bus.div_zero !== 1'b0 || dzs !== 0) begin errors++; $display("FAIL mult_dz[%0d]: got dz=%b stray=%0d expected 0", i, bus.div_zero, dzs); end
    end
    // spot-check the spec's literal values as well as the model
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL mult_zero: got %h_%h expected 0_0", bus.hi, bus.lo); end
  endtask

  task automatic test_div();
    logic [W-1:0] ta [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd3};
    logic [W-1:0] tb [6] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'd10};
    int n, bc, dzs;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(MDU_DIV, ta[i], tb[i]);
      wait_done(n, bc, dzs);
      e = sb.pop_front();
      checks++; if (n !== 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, n); end
      checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin errors++; $display("FAIL div_result[%0d]: got hi=%h lo=%h expected hi=%h lo=%h", i, bus.hi, bus.lo, e.hi, e.lo); end
      checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_dz[%0d]: got %b expected 0", i, bus.div_zero); end
      if (i == 2) begin
        checks++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin errors++; $display("FAIL div_minneg: got hi=%h lo=%h expected 0/80000000", bus.hi, bus.lo); end
      end
    end
  endtask

  task automatic test_div_zero();
    int n, bc, dzs;
    exp_t e;
    issue(MDU_MULT, 32'h00012345, 32'hFFFF0001);
    wait_done(n, bc, dzs);
    void'(sb.pop_front());
    issue(MDU_DIV, 32'd55, 32'd0);
    wait_done(n, bc, dzs);
    e = sb.pop_front();
    checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", n); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", bus.div_zero); end
    checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin errors++; $display("FAIL dz_hold: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    checks++; if (bus.busy !== 1'b0 || bc !== 1) begin errors++; $display("FAIL dz_busy: got busy=%b cycles=%0d expected 0/1", bus.busy, bc); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse: got done=%b dz=%b expected 0/0", bus.done, bus.div_zero); end
  endtask

  task automatic test_start_during_run();
    int n, bc, dzs;
    exp_t e;
    issue(MDU_MULT, 32'd12345, 32'hFFFFFD5A);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd1; bus.b = 32'd0;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(n, bc, dzs);
    e = sb.pop_front();
    checks++; if (n !== 28) begin errors++; $display("FAIL busy_start_latency: got %0d expected 28", n); end
    checks++; if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== 1'b0) begin errors++; $display("FAIL busy_start_result: got %h_%h dz=%b expected %h_%h dz=0", bus.hi, bus.lo, bus.div_zero, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back();
    int n, bc, dzs;
    exp_t e;
    issue(MDU_MULT, 32'hFFFFFFF0, 32'd9);
    wait_done(n, bc, dzs);
    e = sb.pop_front();
    checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin errors++; $display("FAIL b2b_first: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    // request raised while done is showing: ignored for that edge
    push_exp(MDU_DIV, 32'd100, 32'd7);
    bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_ignore: got busy=%b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got done=%b expected 0", bus.done); end
    @(posedge clk); #1 bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy); end
    wait_done(n, bc, dzs);
    e = sb.pop_front();
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
    checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin errors++; $display("FAIL b2b_second: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_mid();
    int n, bc, dzs;
    int seen;
    exp_t e;
    issue(MDU_MULT, 32'h00001234, 32'h00005678);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    void'(sb.pop_back());
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== '0 || bus.lo !== '0) begin errors++; $display("FAIL midrst_hilo: got %h_%h expected 0_0", bus.hi, bus.lo); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
    issue(MDU_DIV, 32'd1000, 32'hFFFFFFFD);
    wait_done(n, bc, dzs);
    e = sb.pop_front();
    checks++; if (n !== 33 || bus.hi !== e.hi || bus.lo !== e.lo) begin errors++; $display("FAIL midrst_restart: got n=%0d %h_%h expected n=33 %h_%h", n, bus.hi, bus.lo, e.hi, e.lo); end
  endtask

  task automatic test_random();
    int n, bc, dzs, exp_n;
    logic op;
    logic [W-1:0] a, b;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? '0 : 32'($urandom);
      if (i == 0) begin op = MDU_DIV; b = '0; end
      exp_n = (op == MDU_DIV && b == '0) ? 1 : 33;
      issue(op, a, b);
      wait_done(n, bc, dzs);
      e = sb.pop_front();
      checks++;
      if (n !== exp_n || bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got n=%0d %h_%h dz=%b expected n=%0d %h_%h dz=%b",
                 i, op, a, b, n, bus.hi, bus.lo, bus.div_zero, exp_n, e.hi, e.lo, e.dz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
